// File: rtl/uart_tx_scheduler_if.sv
// Bus between the requesters (master) and the shared UART transmitter (slave).
// Carries the request/ack handshake, frame status, the serial line and an FSM debug view.
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ = 4
);
    // req[i] is a level held with its req_data byte until ack[i] pulses for one
    // clock; the byte is latched on that edge. Dropping req before ack withdraws it.
    logic                   baud_tick;
    logic [NUM_REQ-1:0]     req;
    logic [8*NUM_REQ-1:0]   req_data;
    logic [NUM_REQ-1:0]     ack;
    logic [2:0]             grant_id;
    logic                   busy;
    logic                   tx;
    logic [2:0]             state_dbg;

    modport master (
        output baud_tick, req, req_data,
        input  ack, grant_id, busy, tx, state_dbg
    );

    modport slave (
        input  baud_tick, req, req_data,
        output ack, grant_id, busy, tx, state_dbg
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin shared UART transmitter: one 8N1 frame per grant, LSB first, bit timing from a 16x baud_tick.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits (11-bit frame).
module uart_tx_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int OVERSAMPLE = 16
) (
    input logic               clock,
    input logic               reset,
    uart_tx_scheduler_if.slave bus
);
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TICK_W = $clog2(OVERSAMPLE + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    state_e             state_q;
    logic               tx_q;
    logic               busy_q;
    logic [NUM_REQ-1:0] ack_q;
    logic [2:0]         grant_q;
    logic [PTR_W-1:0]   rr_ptr_q;
    logic [7:0]         shift_q;
    logic [TICK_W-1:0]  tick_q;
    logic [2:0]         bit_q;
`ifdef UART_TX_PARITY_EN
    logic               parity_q;
`endif

    logic [7:0]         req_byte [NUM_REQ];
    logic               win_found_d;
    logic [PTR_W-1:0]   win_idx_d;
    logic [7:0]         win_data_d;
    logic [PTR_W-1:0]   scan_idx;
    int                 scan_sum;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign req_byte[g] = bus.req_data[8*g +: 8];
    end

    // First set request at or after rr_ptr, wrapping past NUM_REQ-1 back to 0.
    always_comb begin
        win_found_d = 1'b0;
        win_idx_d   = '0;
        win_data_d  = '0;
        scan_idx    = '0;
        scan_sum    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = int'(rr_ptr_q) + k;
            if (scan_sum >= NUM_REQ) scan_sum = scan_sum - NUM_REQ;
            scan_idx = PTR_W'(scan_sum);
            if (!win_found_d && bus.req[scan_idx]) begin
                win_found_d = 1'b1;
                win_idx_d   = scan_idx;
                win_data_d  = req_byte[scan_idx];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            ack_q    <= '0;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            shift_q  <= '0;
            tick_q   <= '0;
            bit_q    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            ack_q <= '0;
            if (state_q == IDLE) begin
                // Ticks seen while idle or on the arbitration cycle never count.
                tick_q <= '0;
                if (win_found_d) begin
                    ack_q[win_idx_d] <= 1'b1;
                    grant_q  <= 3'(win_idx_d);
                    rr_ptr_q <= (win_idx_d == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx_d + 1'b1;
                    shift_q  <= win_data_d;
                    bit_q    <= '0;
                    tx_q     <= 1'b0;
                    busy_q   <= 1'b1;
                    state_q  <= START;
`ifdef UART_TX_PARITY_EN
                    parity_q <= ^win_data_d;
`endif
                end
            end else if (bus.baud_tick) begin
                if (tick_q != TICK_LAST) begin
                    tick_q <= tick_q + 1'b1;
                end else begin
                    tick_q <= '0;
                    case (state_q)
                        START: begin
                            state_q <= DATA;
                            tx_q    <= shift_q[0];
                        end
                        DATA: begin
                            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                                state_q <= PARITY;
                                tx_q    <= parity_q;
`else
                                state_q <= STOP;
                                tx_q    <= 1'b1;
`endif
                            end else begin
                                bit_q   <= bit_q + 1'b1;
                                shift_q <= {1'b0, shift_q[7:1]};
                                tx_q    <= shift_q[1];
                            end
                        end
`ifdef UART_TX_PARITY_EN
                        PARITY: begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end
`endif
                        STOP: begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                        default: begin
                            state_q <= IDLE;
                            tx_q    <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.tx        = tx_q;
    assign bus.busy      = busy_q;
    assign bus.ack       = ack_q;
    assign bus.grant_id  = grant_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: driver pushes {grant, byte} expectations, a monitor
// decodes every frame on tx and checks it against the queue.
module tb_uart_tx_scheduler;
    localparam int NUM_REQ = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int LEN_MIN     = 61 + (FRAME_BITS - 1) * 64;
    localparam int LEN_MAX     = 64 + (FRAME_BITS - 1) * 64;
    localparam int FRAME_LIMIT = 3000;

    logic clock;
    logic reset;
    uart_tx_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

    uart_tx_scheduler #(.NUM_REQ(NUM_REQ), .OVERSAMPLE(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [10:0] exp_q[$];
    int tests_run      = 0;
    int tests_failed   = 0;
    int frames_seen    = 0;
    int frames_aborted = 0;
    int tick_total     = 0;

    // Clock / reset / baud tick
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        bus.baud_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clock);
            bus.baud_tick = 1'b1;
            @(negedge clock);
            bus.baud_tick = 1'b0;
        end
    end

    always @(posedge clock) if (bus.baud_tick) tick_total <= tick_total + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic push_exp(input logic [2:0] id, input logic [7:0] data);
        exp_q.push_back({id, data});
    endtask

    task automatic wait_ack(input int idx);
        int n = 0;
        while (bus.ack[idx] !== 1'b1 && n < FRAME_LIMIT) begin
            @(negedge clock);
            n++;
        end
        check($sformatf("ack_seen_%0d", idx), 32'(bus.ack[idx]), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || bus.busy !== 1'b0) && n < 5000) begin
            @(negedge clock);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        #2 reset = 1'b0;
    endtask

    // Monitor / scoreboard
    initial begin : monitor
        logic [3:0]  ack_cap;
        logic [2:0]  gid_cap;
        logic [10:0] bits_v;
        logic [10:0] e;
        logic        ack_after;
        int          n;
        int          t0;
        bit          aborted;
        forever begin
            @(negedge clock);
            if (reset === 1'b0 && bus.ack !== 4'b0) begin
                ack_cap = bus.ack;
                gid_cap = bus.grant_id;
                t0 = tick_total;
                n = 0;
                aborted = 1'b0;
                bits_v = '0;
                ack_after = 1'b0;
                for (int k = 0; k < FRAME_BITS && !aborted; k++) begin
                    while (!aborted && n < FRAME_LIMIT && (tick_total - t0) < 8 + 16 * k) begin
                        @(negedge clock);
                        n++;
                        if (n == 1) ack_after = |bus.ack;
                        if (reset) aborted = 1'b1;
                    end
                    bits_v[k] = bus.tx;
                end
                while (!aborted && n < FRAME_LIMIT && bus.busy !== 1'b0) begin
                    @(negedge clock);
                    n++;
                    if (reset) aborted = 1'b1;
                end
                if (aborted) begin
                    frames_aborted++;
                end else if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_frame: grant %0d byte %0h, none expected", gid_cap, bits_v[8:1]);
                end else begin
                    e = exp_q.pop_front();
                    frames_seen++;
                    check("grant_id", 32'(gid_cap), 32'(e[10:8]));
                    check("ack_onehot", 32'(ack_cap), 32'(4'b1 << e[10:8]));
                    check("ack_pulse", 32'(ack_after), 32'd0);
                    check("start_bit", 32'(bits_v[0]), 32'd0);
                    check("data_byte", 32'(bits_v[8:1]), 32'(e[7:0]));
`ifdef UART_TX_PARITY_EN
                    check("parity_bit", 32'(bits_v[9]), 32'(^e[7:0]));
`endif
                    check("stop_bit", 32'(bits_v[FRAME_BITS-1]), 32'd1);
                    tests_run++;
                    if (n < LEN_MIN || n > LEN_MAX) begin
                        tests_failed++;
                        $display("FAIL frame_len: got %0d clocks expected %0d..%0d", n, LEN_MIN, LEN_MAX);
                    end
                end
            end
        end
    end

    // Directed stimulus
    initial begin : driver
        int quiet_bad;
        reset = 1'b1;
        bus.req = '0;
        bus.req_data = '0;
        repeat (3) @(negedge clock);
        check("rst_tx", 32'(bus.tx), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_grant", 32'(bus.grant_id), 32'd0);
        check("rst_state", 32'(bus.state_dbg), 32'd0);
        #2 reset = 1'b0;

        // Idle line for 100 clocks
        quiet_bad = 0;
        repeat (100) begin
            @(negedge clock);
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.ack !== 4'b0) quiet_bad++;
        end
        check("idle_quiet", 32'(quiet_bad), 32'd0);

        // Single frame 8'hA5 from requester 0
        push_exp(3'd0, 8'hA5);
        bus.req_data[7:0] = 8'hA5;
        bus.req = 4'b0001;
        wait_ack(0);
        bus.req = 4'b0000;
        wait_idle();

        // All four requesting from rr_ptr=0: grants 0,1,2,3,0 back-to-back
        pulse_reset();
        bus.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        push_exp(3'd0, 8'h11);
        push_exp(3'd1, 8'h22);
        push_exp(3'd2, 8'h33);
        push_exp(3'd3, 8'h44);
        push_exp(3'd0, 8'h11);
        bus.req = 4'b1111;
        wait_ack(0);
        wait_ack(1);
        wait_ack(2);
        wait_ack(3);
        wait_ack(0);
        bus.req = 4'b0000;
        wait_idle();

        // Grant 1 alone (rr_ptr -> 2), then req=0011 wraps to 0 before 1
        push_exp(3'd1, 8'hC3);
        bus.req_data[15:8] = 8'hC3;
        bus.req = 4'b0010;
        wait_ack(1);
        bus.req = 4'b0000;
        bus.req_data[7:0] = 8'h5E;
        bus.req_data[15:8] = 8'h81;
        push_exp(3'd0, 8'h5E);
        push_exp(3'd1, 8'h81);
        bus.req = 4'b0011;
        wait_ack(0);
        bus.req[0] = 1'b0;
        wait_ack(1);
        bus.req[1] = 1'b0;
        wait_idle();

        // Reset during DATA bit 3 of a requester-3 frame; that frame is abandoned
        bus.req_data[31:24] = 8'h00;
        bus.req = 4'b1000;
        wait_ack(3);
        bus.req = 4'b0000;
        repeat (288) @(negedge clock);
        check("mid_state_data", 32'(bus.state_dbg), 32'd2);
        check("mid_tx_low", 32'(bus.tx), 32'd0);
        check("mid_grant", 32'(bus.grant_id), 32'd3);
        #2 reset = 1'b1;
        #1;
        check("async_tx", 32'(bus.tx), 32'd1);
        check("async_busy", 32'(bus.busy), 32'd0);
        check("async_grant", 32'(bus.grant_id), 32'd0);
        check("async_state", 32'(bus.state_dbg), 32'd0);
        @(negedge clock);
        @(negedge clock);
        #2 reset = 1'b0;
        quiet_bad = 0;
        repeat (20) begin
            @(negedge clock);
            if (bus.ack !== 4'b0 || bus.busy !== 1'b0 || bus.tx !== 1'b1) quiet_bad++;
        end
        check("post_reset_quiet", 32'(quiet_bad), 32'd0);
        check("aborted_frames", 32'(frames_aborted), 32'd1);
        push_exp(3'd2, 8'h5A);
        bus.req_data[23:16] = 8'h5A;
        bus.req = 4'b0100;
        wait_ack(2);
        bus.req = 4'b0000;
        wait_idle();

        // Parity-sensitive bytes: 8'h07 (odd weight) and 8'h03 (even weight)
        push_exp(3'd3, 8'h07);
        bus.req_data[31:24] = 8'h07;
        bus.req = 4'b1000;
        wait_ack(3);
        bus.req = 4'b0000;
        push_exp(3'd0, 8'h03);
        bus.req_data[7:0] = 8'h03;
        bus.req = 4'b0001;
        wait_ack(0);
        bus.req = 4'b0000;
        wait_idle();

        check("frames_seen", 32'(frames_seen), 32'd12);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
